// File: rtl/fe_fetch_unit.sv
// Fetch stage. It owns the PC and issues word-aligned requests to a synchronous
// imem with a 1-cycle latency. It predicts not-taken, so the next PC is PC+4.
// Responses go into a small FIFO. The FIFO head is presented to DE with a
// valid/stall handshake.
// A branch mispredict from AGEX flushes the FIFO, drops the in-flight response
// and restarts fetch at the target. The instruction counter is not changed.
module fe_fetch_unit #(
    parameter int               DBITS    = 32,
    parameter int               INSTBITS = 32,
    parameter logic [DBITS-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                br_mispred_i,
    input  logic [DBITS-1:0]    br_target_i,
    input  logic                stall_de_i,
    output logic                imem_req_valid_o,
    output logic [DBITS-1:0]    imem_req_addr_o,
    input  logic [INSTBITS-1:0] imem_rsp_data_i,
    output logic                fe_valid_o,
    output logic [INSTBITS-1:0] fe_inst_o,
    output logic [DBITS-1:0]    fe_pc_o,
    output logic [DBITS-1:0]    fe_pcplus_o,
    output logic [DBITS-1:0]    fe_inst_count_o
);

    localparam int               PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNTW     = $clog2(DEPTH + 1);
    localparam int               OCCW     = CNTW + 1;
    localparam logic [PTRW-1:0]  LAST_PTR = PTRW'(DEPTH - 1);
    localparam logic [OCCW-1:0]  DEPTH_C  = OCCW'(DEPTH);
    localparam logic [DBITS-1:0] FOUR     = DBITS'(4);

    // Control state
    logic [DBITS-1:0] pc_q,            pc_d;
    logic             inflight_q,      inflight_d;
    logic [DBITS-1:0] inflight_addr_q, inflight_addr_d;
    logic [PTRW-1:0]  head_q,          head_d;
    logic [PTRW-1:0]  tail_q,          tail_d;
    logic [CNTW-1:0]  count_q,         count_d;
    logic [DBITS-1:0] inst_count_q,    inst_count_d;

    // FIFO payload
    logic [INSTBITS-1:0] inst_mem_q [DEPTH];
    logic [DBITS-1:0]    pc_mem_q   [DEPTH];

    logic            head_valid;
    logic            deq;
    logic            push;
    logic            issue;
    logic [OCCW-1:0] occ;

    // The low target bits are architecturally ignored.
    logic unused_target_bits;
    assign unused_target_bits = ^br_target_i[1:0];

    function automatic logic [PTRW-1:0] inc_ptr(input logic [PTRW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTRW'(1);
    endfunction

    assign head_valid = (count_q != '0);

    // The occupancy counts the in-flight response, so a slot is already reserved for it.
    assign deq   = head_valid & ~stall_de_i & ~br_mispred_i;
    assign push  = inflight_q & ~br_mispred_i;
    assign occ   = {1'b0, count_q} + OCCW'(inflight_q) - OCCW'(deq);
    assign issue = ~reset & ~br_mispred_i & (occ < DEPTH_C);

    // Next state: a redirect takes priority over everything else; otherwise fetch, push and pop proceed.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave it unassigned (no latch).
        pc_d            = pc_q;
        inflight_d      = issue;
        inflight_addr_d = pc_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        inst_count_d    = inst_count_q;

        if (br_mispred_i) begin
            pc_d       = {br_target_i[DBITS-1:2], 2'b00};
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) pc_d   = pc_q + FOUR;
            if (push)  tail_d = inc_ptr(tail_q);
            if (deq) begin
                head_d       = inc_ptr(head_q);
                inst_count_d = inst_count_q + DBITS'(1);
            end
            count_d = count_q + CNTW'(push) - CNTW'(deq);
        end
    end

    // Control registers: asynchronous reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            inst_count_q    <= '0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            inst_count_q    <= inst_count_d;
        end
    end

    // FIFO payload write: the response is paired with the address that requested it.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is not reset; count_q decides validity and outputs are masked by it.
        if (push) begin
            inst_mem_q[tail_q] <= imem_rsp_data_i;
            pc_mem_q[tail_q]   <= inflight_addr_q;
        end
    end

    assign imem_req_valid_o = issue;
    assign imem_req_addr_o  = pc_q;
    assign fe_valid_o       = head_valid;
    assign fe_inst_o        = head_valid ? inst_mem_q[head_q] : '0;
    assign fe_pc_o          = head_valid ? pc_mem_q[head_q] : '0;
    assign fe_pcplus_o      = head_valid ? pc_mem_q[head_q] + FOUR : '0;
    assign fe_inst_count_o  = inst_count_q;

endmodule

// File: tb/tb_fe_fetch_unit.sv
// Self-checking bench for fe_fetch_unit. It uses a cycle table for the basic
// stream, stall and flush, and hand-written sequences for the redirect corner
// cases and for reset.
// A PC-stream scoreboard checks every instruction that DE accepts.
module tb_fe_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_mispred_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        stall_de_i = 1'b0;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic [31:0] imem_rsp_data_i = '0;
    logic        fe_valid_o;
    logic [31:0] fe_inst_o, fe_pc_o, fe_pcplus_o, fe_inst_count_o;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] mdl_count = '0;
    logic [31:0] sb_q[$];

    fe_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .br_mispred_i    (br_mispred_i),
        .br_target_i     (br_target_i),
        .stall_de_i      (stall_de_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_addr_o (imem_req_addr_o),
        .imem_rsp_data_i (imem_rsp_data_i),
        .fe_valid_o      (fe_valid_o),
        .fe_inst_o       (fe_inst_o),
        .fe_pc_o         (fe_pc_o),
        .fe_pcplus_o     (fe_pcplus_o),
        .fe_inst_count_o (fe_inst_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous imem: one-cycle latency, with junk on cycles that carry no response.
    always @(posedge clk)
        imem_rsp_data_i <= imem_req_valid_o ? inst_of(imem_req_addr_o) : 32'hDEAD_DEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Loads the expected PC stream that starts at base.
    task automatic reseed(input logic [31:0] base);
        sb_q.delete();
        for (int k = 0; k < 64; k++) sb_q.push_back(base + 32'(4 * k));
    endtask

    task automatic score();
        logic [31:0] p;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            p = sb_q.pop_front();
            check("sb_pc", fe_pc_o, p);
            check("sb_inst", fe_inst_o, inst_of(p));
            check("sb_pcplus", fe_pcplus_o, p + 32'd4);
            check("sb_count", fe_inst_count_o, mdl_count);
            mdl_count = mdl_count + 32'd1;
        end
    endtask

    // One cycle: drive at negedge, settle, then score a handshake if there is one.
    task automatic step(input logic rs, input logic st, input logic mp, input logic [31:0] tg);
        @(negedge clk);
        if (reset && !rs) begin
            reseed(32'h0);
            mdl_count = '0;
        end
        reset = rs; stall_de_i = st; br_mispred_i = mp; br_target_i = tg;
        #2;
        if (!rs && fe_valid_o && !st && !mp) score();
        if (!rs && mp) reseed({tg[31:2], 2'b00});
    endtask

    typedef struct {
        logic        st, mp;
        logic [31:0] tg;
        logic        rv;
        logic [31:0] ra;
        logic        chk_fv, fv;
        logic [31:0] pc;
    } vec_t;

    vec_t vt[18];

    task automatic apply_table(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, vt[i].st, vt[i].mp, vt[i].tg);
            check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid_o), 32'(vt[i].rv));
            if (vt[i].rv) check($sformatf("v%0d_req_addr", i), imem_req_addr_o, vt[i].ra);
            if (vt[i].chk_fv) begin
                check($sformatf("v%0d_fe_valid", i), 32'(fe_valid_o), 32'(vt[i].fv));
                if (vt[i].fv) check($sformatf("v%0d_fe_pc", i), fe_pc_o, vt[i].pc);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] cnt_before;
        int          lat;

        // Cycle-by-cycle expectations; entry 0 is the first cycle after reset release.
        vt[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b1, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b1, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 1'b1, 32'h00};
        vt[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 1'b1, 32'h04};
        vt[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 1'b1, 32'h08};
        vt[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h0C};
        vt[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h0C};
        vt[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h0C};
        vt[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h0C};
        vt[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 1'b1, 32'h0C};
        vt[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 1'b1, 32'h10};
        vt[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 1'b1, 32'h14};
        vt[12] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h18};
        vt[13] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
        vt[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b0, 32'h0};
        vt[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 1'b0, 32'h0};
        vt[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 1'b1, 32'h100};
        vt[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 1'b1, 32'h104};

        // Outputs while reset is held.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("rst_req_addr", imem_req_addr_o, 32'h0);
        check("rst_fe_valid", 32'(fe_valid_o), 32'd0);
        check("rst_fe_inst", fe_inst_o, 32'd0);
        check("rst_fe_pc", fe_pc_o, 32'd0);
        check("rst_fe_pcplus", fe_pcplus_o, 32'd0);
        check("rst_count", fe_inst_count_o, 32'd0);

        // Stream, stall with full queue, then flush under stall.
        apply_table(18);

        // Redirect together with stall: the redirect wins and the count holds.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        cnt_before = mdl_count;
        step(1'b0, 1'b1, 1'b1, 32'h40);
        check("t4_count_flush", fe_inst_count_o, cnt_before);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (fe_valid_o) break;
            lat++;
        end
        check("t4_latency", 32'(lat), 32'd2);
        check("t4_pc", fe_pc_o, 32'h40);
        check("t4_count", fe_inst_count_o, cnt_before);

        // Unaligned target, then back-to-back redirects that end at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'h103);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("t5_align", imem_req_addr_o, 32'h100);
        step(1'b0, 1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_last_wins", imem_req_addr_o, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_pc_wrap", imem_req_addr_o, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_head_pc", fe_pc_o, 32'hFFFF_FFFC);
        check("t5_pcplus_wrap", fe_pcplus_o, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset between clock edges: the outputs drop with no edge.
        #1 reset = 1'b1;
        #1;
        check("t6_fe_valid", 32'(fe_valid_o), 32'd0);
        check("t6_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("t6_count", fe_inst_count_o, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t6_req_addr", imem_req_addr_o, 32'h0);
        apply_table(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
